// File: rtl/ex_mem_stage_pkg.sv
// Package: ex_mem_stage_pkg
// Shared definitions for the execute stage: default datapath / register-number widths and the
// 4-bit ALU operation codes. The control unit decodes instructions into these same codes.
package ex_mem_stage_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 5;

  // For ADD, SUB, AND, OR, XOR and LUI only the low three bits are decoded; bit 3 is don't care.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_ZERO = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Module: ex_mem_stage_alu
// Purely combinational ALU of the execute stage.
// Ports:
//   i_a    [Width-1:0]  operand A (shift amount in bits [4:0] for shifts)
//   i_b    [Width-1:0]  operand B (value being shifted for shifts)
//   i_aluc [3:0]        operation code (ALU_* in ex_mem_stage_pkg)
//   o_r    [Width-1:0]  result, wraps modulo 2^Width
//   o_ov                signed overflow, only meaningful for ADD/SUB (0 otherwise)
module ex_mem_stage_alu
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned Width = DW_DEFAULT
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  input  logic [3:0]       i_aluc,
  output logic [Width-1:0] o_r,
  output logic             o_ov
);

  logic [Width-1:0] w_sum;
  logic [Width-1:0] w_diff;
  logic [Width-1:0] w_sll;
  logic [Width-1:0] w_srl;
  logic [Width-1:0] w_sra;
  logic [4:0]       w_sa;

  assign w_sa   = i_a[4:0];
  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_sll  = i_b << w_sa;
  assign w_srl  = i_b >> w_sa;
  assign w_sra  = $unsigned($signed(i_b) >>> w_sa);

  always_comb begin
    o_r  = '0;
    o_ov = 1'b0;
    case (i_aluc[2:0])
      ALU_ADD[2:0]: begin
        o_r  = w_sum;
        // Same-sign operands producing an opposite-sign result.
        o_ov = (i_a[Width-1] == i_b[Width-1]) && (w_sum[Width-1] != i_a[Width-1]);
      end
      ALU_SUB[2:0]: begin
        o_r  = w_diff;
        // Subtraction adds ~b, so the operand-sign test uses the inverted sign of b.
        o_ov = (i_a[Width-1] != i_b[Width-1]) && (w_diff[Width-1] != i_a[Width-1]);
      end
      ALU_AND[2:0]: o_r = i_a & i_b;
      ALU_OR[2:0]:  o_r = i_a | i_b;
      ALU_XOR[2:0]: o_r = i_a ^ i_b;
      ALU_LUI[2:0]: o_r = i_b << 16;
      // x011: only 0011 is a real op (SLL); 1011 yields zero.
      ALU_SLL[2:0]: o_r = (i_aluc == ALU_ZERO) ? '0 : w_sll;
      // x111: bit 3 selects arithmetic vs logical right shift.
      ALU_SRL[2:0]: o_r = (i_aluc == ALU_SRA) ? w_sra : w_srl;
      default: begin
        o_r  = '0;
        o_ov = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Module: ex_mem_stage
// Execute stage plus EX/MEM pipeline register of the 5-stage MIPS-subset core. Selects ALU
// operands, computes the result, and registers result + control for the MEM stage. The
// unregistered result is exported on ex_alu for forwarding back to ID.
// Ports:
//   clk, clr                 clock; asynchronous active-high reset
//   EXwreg/EXm2reg/EXwmem    control from ID/EX (reg write, load writeback, mem write)
//   EXshift, EXaluimm        operand A = shamt / operand B = immediate selects
//   EXaluc [3:0]             ALU operation
//   EXwn [AW-1:0]            destination register
//   EXqa, EXqb, EXimmeOrSa   register operands and extended immediate / shift amount
//   stall, flush             hold the EX/MEM register / load a bubble (flush wins)
//   ex_alu                   combinational ALU result, unaffected by stall/flush
//   MEM*                     registered control, result, store data and overflow
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          EXwreg,
  input  logic          EXm2reg,
  input  logic          EXwmem,
  input  logic          EXshift,
  input  logic          EXaluimm,
  input  logic [3:0]    EXaluc,
  input  logic [AW-1:0] EXwn,
  input  logic [DW-1:0] EXqa,
  input  logic [DW-1:0] EXqb,
  input  logic [DW-1:0] EXimmeOrSa,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] ex_alu,
  output logic          MEMwreg,
  output logic          MEMm2reg,
  output logic          MEMwmem,
  output logic [AW-1:0] MEMwn,
  output logic [DW-1:0] MEMalu,
  output logic [DW-1:0] MEMdi,
  output logic          MEMov
);

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic          w_ov;

  logic          r_wreg;
  logic          r_m2reg;
  logic          r_wmem;
  logic [AW-1:0] r_wn;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_di;
  logic          r_ov;

  // Shift instructions take the shift amount from the immediate field, zero-extended.
  assign w_a = EXshift ? {{(DW - 5){1'b0}}, EXimmeOrSa[4:0]} : EXqa;
  assign w_b = EXaluimm ? EXimmeOrSa : EXqb;

  ex_mem_stage_alu #(
    .Width(DW)
  ) u_alu (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_aluc(EXaluc),
    .o_r   (ex_alu),
    .o_ov  (w_ov)
  );

  // Priority: clr > flush > stall > load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_wn    <= '0;
      r_alu   <= '0;
      r_di    <= '0;
      r_ov    <= 1'b0;
    end else if (flush) begin
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_wn    <= '0;
      r_alu   <= '0;
      r_di    <= '0;
      r_ov    <= 1'b0;
    end else if (!stall) begin
      r_wreg  <= EXwreg;
      r_m2reg <= EXm2reg;
      r_wmem  <= EXwmem;
      r_wn    <= EXwn;
      r_alu   <= ex_alu;
      // Store data is always the register operand, never the immediate.
      r_di    <= EXqb;
      r_ov    <= w_ov;
    end
  end

  assign MEMwreg  = r_wreg;
  assign MEMm2reg = r_m2reg;
  assign MEMwmem  = r_wmem;
  assign MEMwn    = r_wn;
  assign MEMalu   = r_alu;
  assign MEMdi    = r_di;
  assign MEMov    = r_ov;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed vectors with hand-computed ALU results. The stimulus
// process pushes the expected EX/MEM contents into a queue; a monitor pops and compares them
// shortly after each rising edge.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [4:0]  wn;
    logic [31:0] alu;
    logic [31:0] di;
    logic        ov;
  } mem_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        EXwreg, EXm2reg, EXwmem, EXshift, EXaluimm;
  logic [3:0]  EXaluc;
  logic [4:0]  EXwn;
  logic [31:0] EXqa, EXqb, EXimmeOrSa;
  logic        stall, flush;
  logic [31:0] ex_alu;
  logic        MEMwreg, MEMm2reg, MEMwmem;
  logic [4:0]  MEMwn;
  logic [31:0] MEMalu, MEMdi;
  logic        MEMov;

  int n_checks = 0;
  int n_errors = 0;

  mem_t  exp_q[$];
  string name_q[$];
  mem_t  last_exp = '0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk       (clk),
    .clr       (clr),
    .EXwreg    (EXwreg),
    .EXm2reg   (EXm2reg),
    .EXwmem    (EXwmem),
    .EXshift   (EXshift),
    .EXaluimm  (EXaluimm),
    .EXaluc    (EXaluc),
    .EXwn      (EXwn),
    .EXqa      (EXqa),
    .EXqb      (EXqb),
    .EXimmeOrSa(EXimmeOrSa),
    .stall     (stall),
    .flush     (flush),
    .ex_alu    (ex_alu),
    .MEMwreg   (MEMwreg),
    .MEMm2reg  (MEMm2reg),
    .MEMwmem   (MEMwmem),
    .MEMwn     (MEMwn),
    .MEMalu    (MEMalu),
    .MEMdi     (MEMdi),
    .MEMov     (MEMov)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input mem_t e);
    check({name, " MEMwreg"},  {31'b0, MEMwreg},  {31'b0, e.wreg});
    check({name, " MEMm2reg"}, {31'b0, MEMm2reg}, {31'b0, e.m2reg});
    check({name, " MEMwmem"},  {31'b0, MEMwmem},  {31'b0, e.wmem});
    check({name, " MEMwn"},    {27'b0, MEMwn},    {27'b0, e.wn});
    check({name, " MEMalu"},   MEMalu,            e.alu);
    check({name, " MEMdi"},    MEMdi,             e.di);
    check({name, " MEMov"},    {31'b0, MEMov},    {31'b0, e.ov});
  endtask

  // Drive one cycle of inputs on the falling edge, check the forwarding output, and queue the
  // EX/MEM contents expected after the next rising edge.
  task automatic step(input string name, input logic wreg, input logic m2reg, input logic wmem,
                      input logic shift, input logic aluimm, input logic [3:0] aluc,
                      input logic [4:0] wn, input logic [31:0] qa, input logic [31:0] qb,
                      input logic [31:0] imm, input logic [31:0] exp_r, input logic exp_ov,
                      input logic st, input logic fl);
    mem_t e;
    @(negedge clk);
    EXwreg = wreg; EXm2reg = m2reg; EXwmem = wmem; EXshift = shift; EXaluimm = aluimm;
    EXaluc = aluc; EXwn = wn; EXqa = qa; EXqb = qb; EXimmeOrSa = imm;
    stall = st; flush = fl;
    #1;
    check({name, " ex_alu"}, ex_alu, exp_r);
    if (fl) begin
      e = '0;
    end else if (st) begin
      e = last_exp;
    end else begin
      e.wreg = wreg; e.m2reg = m2reg; e.wmem = wmem; e.wn = wn;
      e.alu = exp_r; e.di = qb; e.ov = exp_ov;
    end
    last_exp = e;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: the register updates on the rising edge; compare 2 time units later.
  initial begin
    mem_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check_outputs(nm, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    EXwreg = 0; EXm2reg = 0; EXwmem = 0; EXshift = 0; EXaluimm = 0;
    EXaluc = 4'b0000; EXwn = '0; EXqa = '0; EXqb = '0; EXimmeOrSa = '0;
    stall = 0; flush = 0;
    #1;
    check_outputs("reset", '0);
    @(negedge clk);
    clr = 1'b0;

    //   name        wr m2 wm sh im aluc     wn  qa            qb            imm
    //               expected r    ov st fl
    step("add",      1, 0, 0, 0, 0, 4'b0000, 3, 32'd5,        32'd7,        32'h0,
         32'd12,        0, 0, 0);
    step("sub_ov",   1, 0, 1, 0, 0, 4'b0100, 4, 32'h80000000, 32'h1,        32'h0,
         32'h7FFFFFFF,  1, 0, 0);
    step("add_ov",   1, 0, 0, 0, 0, 4'b0000, 5, 32'h7FFFFFFF, 32'h1,        32'h0,
         32'h80000000,  1, 0, 0);
    step("add_wrap", 1, 0, 0, 0, 0, 4'b0000, 6, 32'hFFFFFFFF, 32'h1,        32'h0,
         32'h0,         0, 0, 0);
    step("add_b3",   1, 0, 0, 0, 0, 4'b1000, 7, 32'd3,        32'd4,        32'h0,
         32'd7,         0, 0, 0);
    step("sub_neg",  1, 0, 0, 0, 0, 4'b1100, 8, 32'd3,        32'd5,        32'h0,
         32'hFFFFFFFE,  0, 0, 0);
    step("and",      0, 1, 0, 0, 0, 4'b0001, 9, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,
         32'h0F000F00,  0, 0, 0);
    step("xor",      1, 0, 0, 0, 0, 4'b1010, 9, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,
         32'hF00FF00F,  0, 0, 0);
    step("zero",     1, 0, 0, 0, 0, 4'b1011, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
         32'h0,         0, 0, 0);
    step("sll",      1, 0, 0, 1, 0, 4'b0011, 10, 32'h1F,      32'hF0000000, 32'h4,
         32'h00000000,  0, 0, 0);
    step("srl",      1, 0, 0, 1, 0, 4'b0111, 11, 32'h1F,      32'hF0000000, 32'h4,
         32'h0F000000,  0, 0, 0);
    step("sra",      1, 0, 0, 1, 0, 4'b1111, 12, 32'h1F,      32'hF0000000, 32'h4,
         32'hFF000000,  0, 0, 0);
    step("sra_mask", 1, 0, 0, 1, 0, 4'b1111, 13, 32'h0,       32'h40000000, 32'h24,
         32'h04000000,  0, 0, 0);
    step("sll_reg",  1, 0, 0, 0, 0, 4'b0011, 14, 32'd8,       32'h1,        32'h0,
         32'h00000100,  0, 0, 0);
    step("lui",      1, 0, 0, 0, 1, 4'b0110, 15, 32'h0,       32'hDEADBEEF, 32'h00001234,
         32'h12340000,  0, 0, 0);
    step("ori",      1, 0, 0, 0, 1, 4'b0101, 16, 32'h00FF0000, 32'h0,       32'h00001234,
         32'h00FF1234,  0, 0, 0);

    // Stall holds the register while inputs change; stall+flush loads a bubble.
    step("ld",       1, 0, 0, 0, 0, 4'b0000, 3, 32'd5,        32'd7,        32'h0,
         32'd12,        0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall",  0, 1, 1, 0, 0, 4'b0100, 20, 32'd9,       32'd2,        32'h0,
           32'd7,       0, 1, 0);
    end
    step("stfl",     1, 0, 1, 0, 0, 4'b0000, 21, 32'd1,       32'd1,        32'h0,
         32'd2,         0, 1, 1);
    step("ld2",      1, 0, 1, 0, 0, 4'b0000, 22, 32'd2,       32'd3,        32'h0,
         32'd5,         0, 0, 0);
    step("flush",    1, 1, 1, 0, 0, 4'b0000, 23, 32'd4,       32'd4,        32'h0,
         32'd8,         0, 0, 1);

    // Asynchronous reset between clock edges while MEMwreg is set.
    step("pre_clr",  1, 0, 0, 0, 0, 4'b0000, 3, 32'd5,        32'd7,        32'h0,
         32'd12,        0, 0, 0);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    check_outputs("async_clr", '0);
    @(negedge clk);
    clr = 1'b0;
    last_exp = '0;
    step("post_clr", 1, 1, 0, 0, 0, 4'b0100, 17, 32'd100,     32'd1,        32'h0,
         32'd99,        0, 0, 0);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
